hazard_stall_ctrl: RTL and testbench

- Pipeline sequencing controller for the 5-stage MIPS core.
- Detects load-use hazards and multiply/divide unit (MDU) interlocks, and generates PC/IF-ID write enables and IF-ID/ID-EX flushes.
- Owns the multi-cycle MDU busy FSM and a saturating stall-cycle counter.
- Sits beside the forwarding logic. Covers only the hazards that forwarding cannot resolve.

---
 rtl/hazard_stall_ctrl.sv | 159 +++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: load-use / MDU interlock detection, PC & IF-ID enables,
// IF-ID/ID-EX flushes, multi-cycle MDU busy FSM and saturating stall counter.
module hazard_stall_ctrl #(
  parameter int MUL_LATENCY = 4,
  parameter int DIV_LATENCY = 32,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          IR_IF_ID_out,
  input  logic [31:0]          IR_ID_EX_out,
  input  logic                 MemRead_ID_EX_out,
  input  logic [1:0]           RegDst_ID_EX_out,
  input  logic                 BranchTaken_EX,
  output logic                 PCWrite,
  output logic                 IF_ID_Write,
  output logic                 IF_ID_Flush,
  output logic                 ID_EX_Flush,
  output logic                 md_start,
  output logic                 md_busy,
  output logic                 md_done,
  output logic [CNT_WIDTH-1:0] stall_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mdState_t;

  localparam int LMAX =
    (DIV_LATENCY > MUL_LATENCY) ? DIV_LATENCY : MUL_LATENCY;
  localparam int CW =
    ($clog2(LMAX) > 6) ? $clog2(LMAX) : 6;
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_LATENCY - 1);
  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_LATENCY - 1);

  mdState_t      state, stateNext;
  logic [CW-1:0] cnt, cntNext;

  logic [5:0] opId, functId, opEx, functEx;
  logic [4:0] rsId, rtId, exDest;
  logic       usesRs, usesRt;
  logic       isMdEx, isDivEx, isMdId, isHiloId;
  logic       loadUse, mdHazard;
  logic       unusedBits;

  assign opId    = IR_IF_ID_out[31:26];
  assign functId = IR_IF_ID_out[5:0];
  assign rsId    = IR_IF_ID_out[25:21];
  assign rtId    = IR_IF_ID_out[20:16];
  assign opEx    = IR_ID_EX_out[31:26];
  assign functEx = IR_ID_EX_out[5:0];

  assign unusedBits = ^{IR_IF_ID_out[15:6],
                        IR_ID_EX_out[25:21],
                        IR_ID_EX_out[10:6]};

  // Shift-immediate forms take their source from rt only.
  assign usesRs = !((opId == 6'h02) || (opId == 6'h03) ||
                    (opId == 6'h0F) ||
                    ((opId == 6'h00) &&
                     ((functId == 6'h00) ||
                      (functId == 6'h02) ||
                      (functId == 6'h03))));

  assign usesRt = (opId == 6'h00) || (opId == 6'h04) ||
                  (opId == 6'h05) || (opId == 6'h2B);

  always_comb begin
    exDest = 5'd31;
    unique case (RegDst_ID_EX_out)
      2'b00:   exDest = IR_ID_EX_out[20:16];
      2'b01:   exDest = IR_ID_EX_out[15:11];
      default: exDest = 5'd31;
    endcase
  end

  assign isMdEx   = (opEx == 6'h00) &&
                    (functEx >= 6'h18) && (functEx <= 6'h1B);
  assign isDivEx  = (functEx == 6'h1A) || (functEx == 6'h1B);
  assign isMdId   = (opId == 6'h00) &&
                    (functId >= 6'h18) && (functId <= 6'h1B);
  assign isHiloId = (opId == 6'h00) &&
                    (functId >= 6'h10) && (functId <= 6'h13);

  assign loadUse = MemRead_ID_EX_out && (exDest != 5'd0) &&
                   (((exDest == rsId) && usesRs) ||
                    ((exDest == rtId) && usesRt));

  assign md_start = reset && isMdEx && (state == IDLE) &&
                    !BranchTaken_EX;

  // DONE does not interlock: HI/LO is already valid then.
  assign mdHazard = (md_start || (state == BUSY)) &&
                    (isMdId || isHiloId);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    case (state)
      IDLE: begin
        if (md_start) begin
          stateNext = BUSY;
          cntNext   = isDivEx ? DIV_LOAD : MUL_LOAD;
        end
      end
      BUSY: begin
        if (cnt != '0) cntNext = cnt - CW'(1);
        else           stateNext = DONE;
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    PCWrite     = 1'b1;
    IF_ID_Write = 1'b1;
    IF_ID_Flush = 1'b0;
    ID_EX_Flush = 1'b0;
    md_busy     = (state == BUSY);
    md_done     = (state == DONE);
    priority case (1'b1)
      !reset: begin
      end
      BranchTaken_EX: begin
        IF_ID_Flush = 1'b1;
        ID_EX_Flush = 1'b1;
      end
      (loadUse || mdHazard): begin
        PCWrite     = 1'b0;
        IF_ID_Write = 1'b0;
        ID_EX_Flush = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count <= '0;
    end else if (!PCWrite && (stall_count != '1)) begin
      stall_count <= stall_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed vectors into a scoreboard queue,
// negedge monitor pops and compares the DUT outputs each cycle.
module tb_hazard_stall_ctrl;

  localparam logic [31:0] NOP    = 32'h0000_0000;
  localparam logic [31:0] LW8    = {6'h23, 5'd29, 5'd8, 16'd0};
  localparam logic [31:0] LW0    = {6'h23, 5'd29, 5'd0, 16'd0};
  localparam logic [31:0] LWRD8  = {6'h23, 5'd29, 5'd3, 5'd8, 11'd0};
  localparam logic [31:0] ADD98  = {6'h0, 5'd8, 5'd10, 5'd9, 5'd0, 6'h20};
  localparam logic [31:0] ADD900 = {6'h0, 5'd0, 5'd0, 5'd9, 5'd0, 6'h20};
  localparam logic [31:0] SLL98  = {6'h0, 5'd0, 5'd8, 5'd9, 5'd2, 6'h00};
  localparam logic [31:0] JMP    = {6'h02, 5'd8, 21'd0};
  localparam logic [31:0] SW8    = {6'h2B, 5'd9, 5'd8, 16'd0};
  localparam logic [31:0] LUI    = {6'h0F, 5'd8, 5'd5, 16'd1};
  localparam logic [31:0] JR31   = {6'h0, 5'd31, 15'd0, 6'h08};
  localparam logic [31:0] MULT   = {6'h0, 5'd4, 5'd5, 10'd0, 6'h18};
  localparam logic [31:0] MFLO   = {6'h0, 10'd0, 5'd2, 5'd0, 6'h12};
  localparam logic [31:0] DIV    = {6'h0, 5'd4, 5'd5, 10'd0, 6'h1A};
  localparam logic [31:0] DIVU   = {6'h0, 5'd4, 5'd5, 10'd0, 6'h1B};

  // {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, start, busy, done}
  localparam logic [6:0] NRM  = 7'b1100000;
  localparam logic [6:0] STL  = 7'b0001000;
  localparam logic [6:0] FLS  = 7'b1111000;
  localparam logic [6:0] STS  = 7'b0001100;
  localparam logic [6:0] STB  = 7'b0001010;
  localparam logic [6:0] DNE  = 7'b1100001;
  localparam logic [6:0] STRT = 7'b1100100;
  localparam logic [6:0] BSY  = 7'b1100010;

  typedef struct packed {
    logic [6:0]  bits;
    logic [15:0] cnt;
    logic [7:0]  tag;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [31:0] IR_IF_ID_out;
  logic [31:0] IR_ID_EX_out;
  logic        MemRead_ID_EX_out;
  logic [1:0]  RegDst_ID_EX_out;
  logic        BranchTaken_EX;
  logic        PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush;
  logic        md_start, md_busy, md_done;
  logic [15:0] stall_count;
  logic        sPCWrite, sIF_ID_Write, sIF_ID_Flush, sID_EX_Flush;
  logic        sMd_start, sMd_busy, sMd_done;
  logic [2:0]  sStall_count;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;
  int   tagN   = 0;

  hazard_stall_ctrl dut (
    .clk(clk), .reset(reset),
    .IR_IF_ID_out(IR_IF_ID_out), .IR_ID_EX_out(IR_ID_EX_out),
    .MemRead_ID_EX_out(MemRead_ID_EX_out),
    .RegDst_ID_EX_out(RegDst_ID_EX_out),
    .BranchTaken_EX(BranchTaken_EX),
    .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write),
    .IF_ID_Flush(IF_ID_Flush), .ID_EX_Flush(ID_EX_Flush),
    .md_start(md_start), .md_busy(md_busy), .md_done(md_done),
    .stall_count(stall_count)
  );

  hazard_stall_ctrl #(.CNT_WIDTH(3)) dutSat (
    .clk(clk), .reset(reset),
    .IR_IF_ID_out(IR_IF_ID_out), .IR_ID_EX_out(IR_ID_EX_out),
    .MemRead_ID_EX_out(MemRead_ID_EX_out),
    .RegDst_ID_EX_out(RegDst_ID_EX_out),
    .BranchTaken_EX(BranchTaken_EX),
    .PCWrite(sPCWrite), .IF_ID_Write(sIF_ID_Write),
    .IF_ID_Flush(sIF_ID_Flush), .ID_EX_Flush(sID_EX_Flush),
    .md_start(sMd_start), .md_busy(sMd_busy), .md_done(sMd_done),
    .stall_count(sStall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic rst, input logic [31:0] id,
                      input logic [31:0] ex, input logic mr,
                      input logic [1:0] rd, input logic br,
                      input logic [6:0] bits, input int c);
    exp_t e;
    @(posedge clk);
    #1;
    reset             = rst;
    IR_IF_ID_out      = id;
    IR_ID_EX_out      = ex;
    MemRead_ID_EX_out = mr;
    RegDst_ID_EX_out  = rd;
    BranchTaken_EX    = br;
    e.bits = bits;
    e.cnt  = 16'(c);
    e.tag  = 8'(tagN);
    tagN++;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [6:0] act, sAct;
      logic [2:0] sCnt;
      e    = sb.pop_front();
      act  = {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush,
              md_start, md_busy, md_done};
      sAct = {sPCWrite, sIF_ID_Write, sIF_ID_Flush, sID_EX_Flush,
              sMd_start, sMd_busy, sMd_done};
      sCnt = (e.cnt > 16'd7) ? 3'd7 : e.cnt[2:0];
      checks++;
      if (act === e.bits) passes++;
      else $display("FAIL ctrl v%0d: got %b want %b", e.tag, act, e.bits);
      checks++;
      if (stall_count === e.cnt) passes++;
      else $display("FAIL stall_count v%0d: got %0d want %0d",
                    e.tag, stall_count, e.cnt);
      checks++;
      if (sAct === e.bits) passes++;
      else $display("FAIL ctrl3 v%0d: got %b want %b", e.tag, sAct, e.bits);
      checks++;
      if (sStall_count === sCnt) passes++;
      else $display("FAIL satcount v%0d: got %0d want %0d",
                    e.tag, sStall_count, sCnt);
    end
  end

  initial begin
    int w;
    reset = 1'b0;
    IR_IF_ID_out = NOP;
    IR_ID_EX_out = NOP;
    MemRead_ID_EX_out = 1'b0;
    RegDst_ID_EX_out = 2'b00;
    BranchTaken_EX = 1'b0;

    step(0, ADD98, MULT, 0, 2'b00, 0, NRM, 0);
    step(0, ADD98, LW8, 1, 2'b00, 0, NRM, 0);
    step(1, ADD98, LW8, 1, 2'b00, 0, STL, 0);
    step(1, ADD98, NOP, 0, 2'b00, 0, NRM, 1);
    step(1, ADD900, LW0, 1, 2'b00, 0, NRM, 1);
    step(1, SLL98, LW8, 1, 2'b00, 0, STL, 1);
    step(1, JMP, LW8, 1, 2'b00, 0, NRM, 2);
    step(1, SW8, LW8, 1, 2'b00, 0, STL, 2);
    step(1, LUI, LW8, 1, 2'b00, 0, NRM, 3);
    step(1, ADD98, LWRD8, 1, 2'b01, 0, STL, 3);
    step(1, ADD98, LWRD8, 1, 2'b00, 0, NRM, 4);
    step(1, JR31, LWRD8, 1, 2'b10, 0, STL, 4);
    step(1, ADD98, LW8, 1, 2'b00, 1, FLS, 5);
    step(1, MFLO, MULT, 0, 2'b00, 1, FLS, 5);
    step(1, NOP, NOP, 0, 2'b00, 0, NRM, 5);

    step(1, MFLO, MULT, 0, 2'b00, 0, STS, 5);
    for (int k = 0; k < 4; k++)
      step(1, MFLO, NOP, 0, 2'b00, 0, STB, 6 + k);
    step(1, MFLO, NOP, 0, 2'b00, 0, DNE, 10);
    step(1, NOP, MFLO, 0, 2'b00, 0, NRM, 10);

    step(1, DIVU, DIV, 0, 2'b00, 0, STS, 10);
    for (int k = 0; k < 32; k++)
      step(1, DIVU, NOP, 0, 2'b00, 0, STB, 11 + k);
    step(1, DIVU, NOP, 0, 2'b00, 0, DNE, 43);
    step(1, NOP, DIVU, 0, 2'b00, 0, STRT, 43);
    for (int k = 0; k < 32; k++)
      step(1, NOP, NOP, 0, 2'b00, 0, BSY, 43);
    step(1, NOP, NOP, 0, 2'b00, 0, DNE, 43);

    step(1, NOP, DIV, 0, 2'b00, 0, STRT, 43);
    for (int k = 0; k < 21; k++)
      step(1, NOP, NOP, 0, 2'b00, 0, BSY, 43);
    step(0, NOP, NOP, 0, 2'b00, 0, NRM, 0);
    step(0, MFLO, DIV, 0, 2'b00, 0, NRM, 0);
    for (int k = 0; k < 40; k++)
      step(1, NOP, NOP, 0, 2'b00, 0, NRM, 0);

    w = 0;
    while (sb.size() > 0 && w < 5) begin
      @(posedge clk);
      w++;
    end
    if (sb.size() > 0) begin
      checks++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
